tag_onchip_mem_arbiter: RTL and testbench

//  Two-master round-robin arbiter for the tag_nios_system single-port on-chip RAM (12288 x 32, byte-enabled).

---
 rtl/tag_onchip_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_tag_onchip_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_onchip_mem_arbiter.sv
// tag_onchip_mem_arbiter: two-master round-robin arbiter in front of a
// single-port, byte-enabled on-chip RAM with 1-cycle read latency.
module tag_onchip_mem_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4,
  parameter int unsigned DEPTH  = 12288
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_err,
  input  logic              m0_err_clr,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_err,
  input  logic              m1_err_clr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0]        sync_q, sync_d;
  logic              last_gnt_q, last_gnt_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic              rd_oor_q, rd_oor_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              req0, req1, gnt0, gnt1, any_gnt;
  logic              sel_wr, in_range, rd_acc;
  logic [ADDR_W-1:0] sel_addr;

  // Round-robin grant; held off until reset release has passed the synchroniser
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (sync_q[1]) begin
      if (req0 && req1) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    any_gnt = gnt0 | gnt1;
  end

  // Mux the granted master onto the RAM port and qualify with the range check
  always_comb begin
    sel_addr       = gnt1 ? m1_address    : m0_address;
    sel_wr         = gnt1 ? m1_write      : m0_write;
    mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    in_range       = (32'(sel_addr) < DEPTH);
    mem_address    = any_gnt ? sel_addr : addr_q;
    mem_chipselect = any_gnt & in_range;
    mem_write      = any_gnt & in_range & sel_wr;
    mem_clken      = reset_n;
    rd_acc         = any_gnt & ~sel_wr;
  end

  // Master-side handshake and read return; out-of-range reads return zero
  always_comb begin
    m0_waitrequest   = req0 & ~gnt0;
    m1_waitrequest   = req1 & ~gnt1;
    m0_readdatavalid = rd_pend_q[0];
    m1_readdatavalid = rd_pend_q[1];
    m0_readdata      = (rd_pend_q[0] & ~rd_oor_q) ? mem_readdata : '0;
    m1_readdata      = (rd_pend_q[1] & ~rd_oor_q) ? mem_readdata : '0;
    m0_err           = err_q[0];
    m1_err           = err_q[1];
  end

  // Next-state for synchroniser, arbitration history, read tracking and errors
  always_comb begin
    sync_d     = {sync_q[0], 1'b1};
    last_gnt_d = last_gnt_q;
    if (gnt1)      last_gnt_d = 1'b1;
    else if (gnt0) last_gnt_d = 1'b0;
    rd_pend_d  = {gnt1 & rd_acc, gnt0 & rd_acc};
    rd_oor_d   = rd_acc & ~in_range;
    err_d[0]   = (gnt0 & ~in_range) | (err_q[0] & ~m0_err_clr);
    err_d[1]   = (gnt1 & ~in_range) | (err_q[1] & ~m1_err_clr);
    addr_d     = mem_address;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b00;
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 2'b00;
      rd_oor_q   <= 1'b0;
      err_q      <= 2'b00;
      addr_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_oor_q   <= rd_oor_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_tag_onchip_mem_arbiter.sv
// Testbench for tag_onchip_mem_arbiter: directed scenarios plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_tag_onchip_mem_arbiter;
  localparam int unsigned DEPTH = 12288;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_i[2], wr_i[2], clr_i[2];
  logic [13:0] addr_i[2];
  logic [31:0] wd_i[2];
  logic [3:0]  be_i[2];

  logic        m0_waitrequest, m0_readdatavalid, m0_err;
  logic        m1_waitrequest, m1_readdatavalid, m1_err;
  logic [31:0] m0_readdata, m1_readdata;
  logic [13:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tag_onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(addr_i[0]), .m0_read(rd_i[0]), .m0_write(wr_i[0]),
    .m0_writedata(wd_i[0]), .m0_byteenable(be_i[0]),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_err(m0_err), .m0_err_clr(clr_i[0]),
    .m1_address(addr_i[1]), .m1_read(rd_i[1]), .m1_write(wr_i[1]),
    .m1_writedata(wd_i[1]), .m1_byteenable(be_i[1]),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid), .m1_err(m1_err), .m1_err_clr(clr_i[1]),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Power-up contents of every word, distinct per address
  function automatic logic [31:0] init_word(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  // Environment RAM: registered read, byte-enabled write
  bit   [31:0] ram [DEPTH];
  bit          ram_w [DEPTH];
  logic [31:0] ram_q = 32'h0;
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect && (32'(mem_address) < DEPTH)) begin
      if (mem_write) begin
        logic [31:0] v;
        v = ram_w[mem_address] ? ram[mem_address] : init_word(mem_address);
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) v[8*b +: 8] = mem_writedata[8*b +: 8];
        ram[mem_address]   <= v;
        ram_w[mem_address] <= 1'b1;
      end else begin
        ram_q <= ram_w[mem_address] ? ram[mem_address] : init_word(mem_address);
      end
    end
  end

  // Reference model state
  bit   [31:0] mm [DEPTH];
  bit          mm_w [DEPTH];
  bit          md_pend[2];
  logic [31:0] md_pdata[2];
  bit          md_err[2];
  int          md_last;
  logic [13:0] md_addr;
  int          md_dis;
  int          last_g;

  function automatic logic [31:0] mread(input logic [13:0] a);
    return mm_w[a] ? mm[a] : init_word(a);
  endfunction

  function automatic logic req(input int n);
    return rd_i[n] | wr_i[n];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  task automatic model_check();
    logic        w[2], v[2], e[2];
    logic [31:0] d[2];
    logic [31:0] nv;
    bit          np[2], ne[2], inr;
    int          g;
    w[0] = m0_waitrequest;   w[1] = m1_waitrequest;
    v[0] = m0_readdatavalid; v[1] = m1_readdatavalid;
    e[0] = m0_err;           e[1] = m1_err;
    d[0] = m0_readdata;      d[1] = m1_readdata;
    if (!reset_n) begin
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("rst_m%0d_wait", n), 32'(w[n]), 32'(req(n)));
        chk($sformatf("rst_m%0d_rdv", n), 32'(v[n]), 32'h0);
        chk($sformatf("rst_m%0d_rdata", n), d[n], 32'h0);
        chk($sformatf("rst_m%0d_err", n), 32'(e[n]), 32'h0);
        md_pend[n] = 1'b0;
        md_err[n]  = 1'b0;
      end
      chk("rst_mem_addr", 32'(mem_address), 32'h0);
      chk("rst_mem_cs", 32'(mem_chipselect), 32'h0);
      chk("rst_mem_wr", 32'(mem_write), 32'h0);
      chk("rst_mem_clken", 32'(mem_clken), 32'h0);
      md_last = 1; md_addr = 14'h0; md_dis = 2; last_g = -1;
      return;
    end
    chk("mem_clken", 32'(mem_clken), 32'h1);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("m%0d_rdv", n), 32'(v[n]), 32'(md_pend[n]));
      if (md_pend[n]) chk($sformatf("m%0d_rdata", n), d[n], md_pdata[n]);
      chk($sformatf("m%0d_err", n), 32'(e[n]), 32'(md_err[n]));
    end
    g = -1;
    if (md_dis > 0) md_dis--;
    else if (req(0) && req(1)) g = (md_last == 1) ? 0 : 1;
    else if (req(0)) g = 0;
    else if (req(1)) g = 1;
    last_g = g;
    for (int n = 0; n < 2; n++)
      chk($sformatf("m%0d_wait", n), 32'(w[n]), 32'(req(n) && (g != n)));
    inr = 1'b0;
    if (g >= 0) begin
      inr = (32'(addr_i[g]) < DEPTH);
      chk("mem_addr", 32'(mem_address), 32'(addr_i[g]));
      chk("mem_cs", 32'(mem_chipselect), 32'(inr));
      chk("mem_wr", 32'(mem_write), 32'(inr && wr_i[g]));
      if (inr) begin
        chk("mem_wdata", mem_writedata, wd_i[g]);
        chk("mem_be", 32'(mem_byteenable), 32'(be_i[g]));
      end
    end else begin
      chk("idle_addr", 32'(mem_address), 32'(md_addr));
      chk("idle_cs", 32'(mem_chipselect), 32'h0);
      chk("idle_wr", 32'(mem_write), 32'h0);
    end
    for (int n = 0; n < 2; n++) begin
      np[n] = 1'b0;
      ne[n] = md_err[n] && !clr_i[n];
    end
    if (g >= 0) begin
      md_addr = addr_i[g];
      md_last = g;
      if (!inr) ne[g] = 1'b1;
      if (wr_i[g]) begin
        if (inr) begin
          nv = mread(addr_i[g]);
          for (int b = 0; b < 4; b++)
            if (be_i[g][b]) nv[8*b +: 8] = wd_i[g][8*b +: 8];
          mm[addr_i[g]]   = nv;
          mm_w[addr_i[g]] = 1'b1;
        end
      end else begin
        np[g]       = 1'b1;
        md_pdata[g] = inr ? mread(addr_i[g]) : 32'h0;
      end
    end
    md_pend = np;
    md_err  = ne;
  endtask

  task automatic at_neg(); @(negedge clk); model_check(); endtask
  task automatic to_pos(); @(posedge clk); #1; endtask
  task automatic cyc(); at_neg(); to_pos(); endtask

  task automatic setm(input int n, input logic r, input logic w, input logic [13:0] a,
                      input logic [31:0] dd, input logic [3:0] be);
    rd_i[n] = r; wr_i[n] = w; addr_i[n] = a; wd_i[n] = dd; be_i[n] = be;
  endtask

  task automatic idle(input int n);
    rd_i[n] = 1'b0; wr_i[n] = 1'b0; clr_i[n] = 1'b0;
  endtask

  bit          act[2];
  logic        a_rd[2], a_wr[2];
  logic [13:0] a_ad[2];
  logic [31:0] a_wd[2];
  logic [3:0]  a_be[2];

  initial begin
    for (int n = 0; n < 2; n++) begin
      setm(n, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
      clr_i[n] = 1'b0;
      act[n] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (2) cyc();

    // Write then read back from m0
    setm(0, 1'b0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
    at_neg(); chk("t1_wr_wait", 32'(m0_waitrequest), 32'h0); chk("t1_mem_write", 32'(mem_write), 32'h1); to_pos();
    setm(0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF);
    at_neg(); chk("t1_rd_wait", 32'(m0_waitrequest), 32'h0); to_pos();
    idle(0);
    at_neg(); chk("t1_rdv", 32'(m0_readdatavalid), 32'h1); chk("t1_rdata", m0_readdata, 32'hDEADBEEF); to_pos();

    // Continuous contention: m0 served last, so m1 wins the first tie
    setm(0, 1'b1, 1'b0, 14'h0001, 32'h0, 4'hF);
    setm(1, 1'b1, 1'b0, 14'h0002, 32'h0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      chk("t2_m0_wait", 32'(m0_waitrequest), 32'((k % 2) == 0));
      chk("t2_m1_wait", 32'(m1_waitrequest), 32'((k % 2) == 1));
      if (k > 0) begin
        chk("t2_m0_rdv", 32'(m0_readdatavalid), 32'((k % 2) == 0));
        chk("t2_m1_rdv", 32'(m1_readdatavalid), 32'((k % 2) == 1));
        if ((k % 2) == 0) chk("t2_m0_data", m0_readdata, 32'hC0DE0001);
        else              chk("t2_m1_data", m1_readdata, 32'hC0DE0002);
      end
      to_pos();
    end
    idle(0); idle(1);
    cyc();

    // Partial byte-enable write over all-ones
    setm(1, 1'b0, 1'b1, 14'h0020, 32'hFFFFFFFF, 4'hF); cyc();
    setm(1, 1'b0, 1'b1, 14'h0020, 32'h11223344, 4'h3); cyc();
    setm(1, 1'b1, 1'b0, 14'h0020, 32'h0, 4'hF); cyc();
    idle(1);
    at_neg(); chk("t3_rdv", 32'(m1_readdatavalid), 32'h1); chk("t3_rdata", m1_readdata, 32'hFFFF3344); to_pos();

    // Out-of-range read from m1 while m0 keeps working
    setm(1, 1'b1, 1'b0, 14'h3000, 32'h0, 4'hF);
    at_neg(); chk("t4_cs", 32'(mem_chipselect), 32'h0); chk("t4_wait", 32'(m1_waitrequest), 32'h0); to_pos();
    idle(1); setm(0, 1'b1, 1'b0, 14'h0001, 32'h0, 4'hF);
    at_neg();
    chk("t4_rdv", 32'(m1_readdatavalid), 32'h1); chk("t4_rdata", m1_readdata, 32'h0);
    chk("t4_err", 32'(m1_err), 32'h1); chk("t4_m0_cs", 32'(mem_chipselect), 32'h1);
    to_pos();
    idle(0);
    at_neg(); chk("t4_m0_data", m0_readdata, 32'hC0DE0001); chk("t4_err_hold", 32'(m1_err), 32'h1); to_pos();
    clr_i[1] = 1'b1; cyc();
    clr_i[1] = 1'b0;
    at_neg(); chk("t4_err_clr", 32'(m1_err), 32'h0); to_pos();

    // Reset right after an accepted read
    setm(0, 1'b1, 1'b0, 14'h0003, 32'h0, 4'hF);
    at_neg(); chk("t5_wait", 32'(m0_waitrequest), 32'h0); to_pos();
    idle(0); reset_n = 1'b0;
    at_neg();
    chk("t5_rdv", 32'(m0_readdatavalid), 32'h0); chk("t5_clken", 32'(mem_clken), 32'h0);
    chk("t5_cs", 32'(mem_chipselect), 32'h0); chk("t5_addr", 32'(mem_address), 32'h0);
    to_pos();
    cyc();
    reset_n = 1'b1;
    setm(0, 1'b1, 1'b0, 14'h0004, 32'h0, 4'hF);
    setm(1, 1'b1, 1'b0, 14'h0005, 32'h0, 4'hF);
    cyc(); cyc();
    at_neg(); chk("t5_tie_m0", 32'(m0_waitrequest), 32'h0); chk("t5_tie_m1", 32'(m1_waitrequest), 32'h1); to_pos();
    idle(0); cyc();
    idle(1); cyc(); cyc();

    // Read+write together behaves as a write
    setm(0, 1'b1, 1'b1, 14'h0005, 32'hA5A5A5A5, 4'hF);
    at_neg(); chk("t6_mem_write", 32'(mem_write), 32'h1); to_pos();
    idle(0);
    at_neg(); chk("t6_no_rdv", 32'(m0_readdatavalid), 32'h0); to_pos();
    setm(0, 1'b1, 1'b0, 14'h0005, 32'h0, 4'hF); cyc();
    idle(0);
    at_neg(); chk("t6_rdata", m0_readdata, 32'hA5A5A5A5); to_pos();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        act[0] = 1'b0; act[1] = 1'b0;
      end
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 9) < 6) begin
          int t, s;
          t = int'($urandom_range(0, 9));
          s = int'($urandom_range(0, 9));
          act[n]  = 1'b1;
          a_rd[n] = (t < 4) || (t >= 8);
          a_wr[n] = (t >= 4);
          if (s < 6)       a_ad[n] = 14'($urandom_range(0, 31));
          else if (s == 6) a_ad[n] = 14'd12287;
          else if (s == 7) a_ad[n] = 14'd12288;
          else if (s == 8) a_ad[n] = 14'h3FFF;
          else             a_ad[n] = 14'($urandom);
          a_wd[n] = $urandom;
          a_be[n] = 4'($urandom);
        end
        if (act[n]) setm(n, a_rd[n], a_wr[n], a_ad[n], a_wd[n], a_be[n]);
        else begin rd_i[n] = 1'b0; wr_i[n] = 1'b0; end
        clr_i[n] = ($urandom_range(0, 9) == 0);
      end
      at_neg();
      if (last_g >= 0) act[last_g] = 1'b0;
      to_pos();
    end
    idle(0); idle(1);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
